instr_loader: RTL and testbench

INSTR_LOADER -- requirements
Module: instr_loader

---
 rtl/instr_loader_pkg.sv | 26 ++
 rtl/instr_loader_if.sv | 28 ++
 rtl/instr_ram.sv | 25 ++
 rtl/instr_loader.sv | 98 +++++++++
 tb/tb_instr_loader.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/instr_loader_pkg.sv
// Shared definitions for the instruction loader: FSM encoding, sizing defaults
// and the bit positions of the fields inside an 8-bit instruction.
package instr_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  localparam int         DEPTH_DEFAULT = 64;
  localparam logic [7:0] FILL_DEFAULT  = 8'h00;
  localparam int         LEN_W         = 7;

  // Instruction byte layout: {op, rs, rt, rd/imm}, two bits each.
  localparam int FIELD_W = 2;
  localparam int OP_LSB  = 6;
  localparam int RS_LSB  = 4;
  localparam int RT_LSB  = 2;
  localparam int RD_LSB  = 0;

  function automatic logic [FIELD_W-1:0] instr_op(input logic [7:0] instr);
    return instr[OP_LSB +: FIELD_W];
  endfunction

endpackage

// File: rtl/instr_loader_if.sv
// Byte-stream load channel, instruction fetch port and run-control status
// shared between the program source / processor and the loader.
interface instr_loader_if;

  logic       load_start;
  logic       load_valid;
  logic [7:0] load_data;
  logic       load_last;
  logic       load_ready;

  logic [7:0] read_address;
  logic [7:0] instruction;

  logic       cpu_reset;
  logic [6:0] prog_len;
  logic       overflow;

  modport master (
    output load_start, load_valid, load_data, load_last, read_address,
    input  load_ready, instruction, cpu_reset, prog_len, overflow
  );

  modport slave (
    input  load_start, load_valid, load_data, load_last, read_address,
    output load_ready, instruction, cpu_reset, prog_len, overflow
  );

endinterface

// File: rtl/instr_ram.sv
// Instruction storage: synchronous write, asynchronous (zero-latency) read.
// Contents are deliberately not reset; the loader masks stale words.
module instr_ram #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instr_loader.sv
// Loads a program byte stream into instruction memory while holding the
// processor in reset, then releases it and serves fetches combinationally.
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int         DEPTH = DEPTH_DEFAULT,
  parameter logic [7:0] FILL  = FILL_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  instr_loader_if.slave      bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t           state_reg;
  logic [LEN_W-1:0] wr_ptr_reg;
  logic             overflow_reg;
  logic             ready_reg;
  logic             cpu_reset_reg;

  logic             load_ready;
  logic             accept;
  logic             last_slot;
  logic             in_range;
  logic [7:0]       ram_rdata;

  // A restart pulse wins over any byte presented in the same cycle.
  assign load_ready = ready_reg & ~bus.load_start;
  assign accept     = bus.load_valid & load_ready;
  assign last_slot  = (wr_ptr_reg == LEN_W'(DEPTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      wr_ptr_reg    <= '0;
      overflow_reg  <= 1'b0;
      ready_reg     <= 1'b0;
      cpu_reset_reg <= 1'b1;
    end else begin
      case (state_reg)
        ST_IDLE, ST_RUN: begin
          if (bus.load_start) begin
            state_reg     <= ST_LOAD;
            wr_ptr_reg    <= '0;
            overflow_reg  <= 1'b0;
            ready_reg     <= 1'b1;
            cpu_reset_reg <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (bus.load_start) begin
            wr_ptr_reg   <= '0;
            overflow_reg <= 1'b0;
          end else if (accept) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (bus.load_last || last_slot) begin
              state_reg     <= ST_RUN;
              ready_reg     <= 1'b0;
              cpu_reset_reg <= 1'b0;
              overflow_reg  <= ~bus.load_last;
            end
          end
        end
        default: begin
          state_reg     <= ST_IDLE;
          wr_ptr_reg    <= '0;
          overflow_reg  <= 1'b0;
          ready_reg     <= 1'b0;
          cpu_reset_reg <= 1'b1;
        end
      endcase
    end
  end

  instr_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (accept),
    .waddr (wr_ptr_reg[AW-1:0]),
    .wdata (bus.load_data),
    .raddr (bus.read_address[AW-1:0]),
    .rdata (ram_rdata)
  );

  // prog_len masks both stale words and addresses beyond the array.
  assign in_range = (bus.read_address < {1'b0, wr_ptr_reg}) &&
                    (int'(bus.read_address) < DEPTH);

  assign bus.instruction = in_range ? ram_rdata : FILL;
  assign bus.load_ready  = load_ready;
  assign bus.cpu_reset   = cpu_reset_reg;
  assign bus.prog_len    = wr_ptr_reg;
  assign bus.overflow    = overflow_reg;

endmodule

// File: tb/tb_instr_loader.sv
// Randomized check of instr_loader against a behavioural program-memory model.
module tb_instr_loader;
  import instr_loader_pkg::*;

  localparam int         DEPTH = 64;
  localparam logic [7:0] FILL  = 8'h00;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instr_loader_if bus();

  instr_loader #(
    .DEPTH (DEPTH),
    .FILL  (FILL)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: what a correct loader holds after each edge.
  logic [7:0] mem_m [DEPTH];
  int         len_m;
  bit         loading_m;
  bit         running_m;
  bit         ovf_m;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_status();
    check("cpu_reset", 32'(bus.cpu_reset), 32'(!running_m));
    check("prog_len",  32'(bus.prog_len),  32'(len_m));
    check("overflow",  32'(bus.overflow),  32'(ovf_m));
  endtask

  task automatic cyc(input bit st, input bit v, input logic [7:0] d, input bit l);
    bit acc;
    @(negedge clk);
    bus.load_start = st;
    bus.load_valid = v;
    bus.load_data  = d;
    bus.load_last  = l;
    #1;
    check("load_ready", 32'(bus.load_ready), 32'(loading_m && !st));
    acc = loading_m && !st && v;
    @(posedge clk);
    if (st) begin
      loading_m = 1'b1;
      running_m = 1'b0;
      len_m     = 0;
      ovf_m     = 1'b0;
      $display("[TB] load_start");
    end else if (acc) begin
      mem_m[len_m] = d;
      len_m++;
      $display("[TB] accept addr=%0d data=%02h op=%0d last=%0b", len_m - 1, d, instr_op(d), l);
      if (l || len_m == DEPTH) begin
        loading_m = 1'b0;
        running_m = 1'b1;
        ovf_m     = !l;
      end
    end
    #1;
    check_status();
    bus.load_start = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_last  = 1'b0;
  endtask

  task automatic check_reads();
    logic [7:0] exp;
    for (int a = 0; a <= DEPTH + 2; a++) begin
      bus.read_address = 8'(a);
      #1;
      exp = (a < len_m) ? mem_m[a] : FILL;
      check($sformatf("rd%0d", a), 32'(bus.instruction), 32'(exp));
    end
    bus.read_address = 8'hFF;
    #1;
    check("rd255", 32'(bus.instruction), 32'(FILL));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    loading_m = 1'b0;
    running_m = 1'b0;
    len_m     = 0;
    ovf_m     = 1'b0;
    #1;
    check("rst_ready", 32'(bus.load_ready), 32'(0));
    check_status();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    $display("[TB] reset");
  endtask

  task automatic send_program(input int n, input bit with_last, input int gap_pct);
    int  i = 0;
    bit  v;
    bit  l;
    while (i < n) begin
      v = ($urandom_range(99) >= gap_pct);
      l = with_last && (i == n - 1) && v;
      cyc(1'b0, v, 8'($urandom), l);
      if (v) i++;
    end
  endtask

  initial begin
    rst              = 1'b1;
    bus.load_start   = 1'b0;
    bus.load_valid   = 1'b0;
    bus.load_data    = 8'h00;
    bus.load_last    = 1'b0;
    bus.read_address = 8'h00;
    for (int i = 0; i < DEPTH; i++) mem_m[i] = 8'h00;

    // Reset state and fetches with nothing loaded.
    do_reset();
    bus.read_address = 8'd0; #1;
    check("rst_rd0", 32'(bus.instruction), 32'(8'h00));
    bus.read_address = 8'd5; #1;
    check("rst_rd5", 32'(bus.instruction), 32'(8'h00));
    repeat (2) cyc(1'b0, 1'b1, 8'($urandom), 1'b1);

    // Short fixed program.
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    cyc(1'b0, 1'b1, 8'h06, 1'b0);
    cyc(1'b0, 1'b1, 8'h53, 1'b0);
    cyc(1'b0, 1'b1, 8'hC0, 1'b1);
    check_reads();

    // Bytes offered while running are ignored.
    repeat (3) cyc(1'b0, 1'b1, 8'($urandom), 1'($urandom));
    check_reads();

    // Load with valid gaps.
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    send_program(12, 1'b1, 40);
    check_reads();

    // Full array without load_last overflows; further bytes are refused.
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    send_program(DEPTH, 1'b0, 20);
    check_reads();
    cyc(1'b0, 1'b1, 8'h3C, 1'b0);

    // Full array ending with load_last does not overflow.
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    send_program(DEPTH, 1'b1, 0);
    check_reads();

    // Reload from RUN, then reset after two bytes.
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    send_program(2, 1'b0, 0);
    do_reset();
    check_reads();
    cyc(1'b0, 1'b1, 8'h11, 1'b0);

    // Restart during a load; the byte offered with the restart is dropped.
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    send_program(2, 1'b0, 0);
    cyc(1'b1, 1'b1, 8'hAA, 1'b0);
    cyc(1'b0, 1'b1, 8'h5A, 1'b0);
    cyc(1'b0, 1'b1, 8'h77, 1'b1);
    check_reads();

    // Random programs.
    for (int k = 0; k < 6; k++) begin
      cyc(1'b1, 1'b0, 8'h00, 1'b0);
      send_program($urandom_range(DEPTH, 1), 1'($urandom), 30);
      check_reads();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
